// File: rtl/cnt_share_arbiter.sv
// Two-requester arbiter in front of one shared loadable counter: one command
// in flight at a time. Optional build macro: CNT_ARB_FIXED_PRIO_EN.
module cnt_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int RSP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             cnt_load_e,
  output logic             cnt_out_e,
  output logic [WIDTH-1:0] cnt_load_val,
  input  logic [WIDTH-1:0] cnt_out_data,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a command transfers on a cycle where reqN_valid && reqN_ready.
  // Ready is only offered in IDLE, to the granted requester, and never in reset.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT = 3'(RSP_LAT);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_op;
  logic             r_id;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_rsp_data;
  logic [WIDTH-1:0] r_load_val;
  logic [2:0]       r_wait_cnt;

  logic             w_grant_vld;
  logic             w_grant;
  logic             w_xfer;
  logic             w_xfer_op;
  logic [WIDTH-1:0] w_xfer_data;

`ifndef CNT_ARB_FIXED_PRIO_EN
  logic             r_last_grant;
`endif

  always_comb begin
    w_grant_vld = req0_valid | req1_valid;
    w_grant     = 1'b0;
`ifdef CNT_ARB_FIXED_PRIO_EN
    w_grant = !req0_valid;
`else
    // Under contention the requester not served last wins.
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = req1_valid;
    end
`endif
  end

  assign req0_ready  = (r_state == IDLE) && w_grant_vld && !w_grant && !rst;
  assign req1_ready  = (r_state == IDLE) && w_grant_vld &&  w_grant && !rst;
  assign w_xfer      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign w_xfer_op   = w_grant ? req1_op : req0_op;
  assign w_xfer_data = w_grant ? req1_data : req0_data;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_xfer) w_next_state = ISSUE;
      ISSUE:   w_next_state = r_op ? WAIT : RESP;
      WAIT:    if (r_wait_cnt == 3'd1) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign cnt_load_e   = (r_state == ISSUE) && !r_op;
  assign cnt_out_e    = (r_state == ISSUE) &&  r_op;
  assign cnt_load_val = r_load_val;
  assign rsp0_valid   = (r_state == RESP) && !r_id;
  assign rsp1_valid   = (r_state == RESP) &&  r_id;
  assign rsp_data     = r_rsp_data;
  assign busy         = (r_state != IDLE);
  assign dbg_state    = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= 1'b0;
      r_id       <= 1'b0;
      r_data     <= '0;
      r_rsp_data <= '0;
      r_load_val <= '0;
      r_wait_cnt <= '0;
`ifndef CNT_ARB_FIXED_PRIO_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      r_state <= w_next_state;
      if (w_xfer) begin
        r_op   <= w_xfer_op;
        r_data <= w_xfer_data;
        r_id   <= w_grant;
`ifndef CNT_ARB_FIXED_PRIO_EN
        r_last_grant <= w_grant;
`endif
        // Load value is presented from the strobe cycle and held afterwards.
        if (!w_xfer_op) r_load_val <= w_xfer_data;
      end
      if (r_state == ISSUE) begin
        if (r_op) r_wait_cnt <= LAT;
        else      r_rsp_data <= r_data;
      end
      if (r_state == WAIT) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
        if (r_wait_cnt == 3'd1) r_rsp_data <= cnt_out_data;
      end
    end
  end

endmodule

// File: tb/tb_cnt_share_arbiter.sv
// Bench for cnt_share_arbiter: directed timing checks plus a response
// scoreboard; a second instance covers RSP_LAT=3.
module tb_cnt_share_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_op, req1_valid, req1_op;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [7:0] rsp_data, cnt_load_val, cnt_out_data;
  logic       cnt_load_e, cnt_out_e, busy;
  logic [1:0] dbg_state;

  logic       d3_req0_valid, d3_req0_op, d3_req1_valid, d3_req1_op;
  logic [7:0] d3_req0_data, d3_req1_data;
  logic       d3_req0_ready, d3_req1_ready, d3_rsp0_valid, d3_rsp1_valid;
  logic [7:0] d3_rsp_data, d3_cnt_load_val, d3_cnt_out_data;
  logic       d3_cnt_load_e, d3_cnt_out_e, d3_busy;
  logic [1:0] d3_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];
  logic [7:0] load_q[$];

  always #5 clk = ~clk;

  cnt_share_arbiter #(.WIDTH(8), .RSP_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .cnt_load_e(cnt_load_e), .cnt_out_e(cnt_out_e), .cnt_load_val(cnt_load_val),
    .cnt_out_data(cnt_out_data), .busy(busy), .dbg_state(dbg_state)
  );

  cnt_share_arbiter #(.WIDTH(8), .RSP_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(d3_req0_valid), .req0_op(d3_req0_op), .req0_data(d3_req0_data), .req0_ready(d3_req0_ready),
    .req1_valid(d3_req1_valid), .req1_op(d3_req1_op), .req1_data(d3_req1_data), .req1_ready(d3_req1_ready),
    .rsp0_valid(d3_rsp0_valid), .rsp1_valid(d3_rsp1_valid), .rsp_data(d3_rsp_data),
    .cnt_load_e(d3_cnt_load_e), .cnt_out_e(d3_cnt_out_e), .cnt_load_val(d3_cnt_load_val),
    .cnt_out_data(d3_cnt_out_data), .busy(d3_busy), .dbg_state(d3_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: responses and load strobes checked against queued expectations.
  always @(negedge clk) begin
    if (cnt_load_e || cnt_out_e) check("strobe_excl", {31'd0, cnt_load_e & cnt_out_e}, 32'd0);
    if (cnt_load_e) begin
      if (load_q.size() == 0) check("load_unexpected", 32'd1, 32'd0);
      else check("load_val", {24'd0, cnt_load_val}, {24'd0, load_q.pop_front()});
    end
    if (rsp0_valid || rsp1_valid) begin
      check("rsp_onehot", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
      if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else check("rsp_id_data", {23'd0, rsp1_valid, rsp_data}, {23'd0, exp_q.pop_front()});
    end
  end

  // One uncontended command on the main instance; returns to IDLE-ready time.
  task automatic do_op(input logic id, input logic op, input logic [7:0] data, input logic [7:0] rd_val);
    cnt_out_data = rd_val;
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_data = data; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_data = data; end
    @(negedge clk);
    check(id ? "rnd_ready1" : "rnd_ready0", {31'd0, id ? req1_ready : req0_ready}, 32'd1);
    exp_q.push_back({id, op ? rd_val : data});
    if (!op) load_q.push_back(data);
    next_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (op ? 3 : 2) next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g;
    req0_valid = 0; req0_op = 0; req0_data = 0;
    req1_valid = 0; req1_op = 0; req1_data = 0;
    cnt_out_data = 8'h00;
    d3_req0_valid = 0; d3_req0_op = 0; d3_req0_data = 0;
    d3_req1_valid = 0; d3_req1_op = 0; d3_req1_data = 0;
    d3_cnt_out_data = 8'h00;

    // Reset state, ready suppressed while rst is high.
    rst = 1'b1;
    req0_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_outs", {16'd0, rsp0_valid, rsp1_valid, cnt_load_e, cnt_out_e, dbg_state, 2'd0, rsp_data}, 32'd0);
    check("rst_load_val", {24'd0, cnt_load_val}, 32'd0);
    next_cycle();
    req0_valid = 1'b0;
    next_cycle();
    rst = 1'b0;

    // req0 LOAD 0x5A alone.
    req0_valid = 1'b1; req0_op = 1'b0; req0_data = 8'h5A;
    @(negedge clk);
    check("t1_ready0", {31'd0, req0_ready}, 32'd1);
    exp_q.push_back({1'b0, 8'h5A});
    load_q.push_back(8'h5A);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    check("t1_load_e", {31'd0, cnt_load_e}, 32'd1);
    check("t1_load_val", {24'd0, cnt_load_val}, 32'h5A);
    next_cycle();
    @(negedge clk);
    check("t1_rsp0", {30'd0, rsp0_valid, rsp1_valid}, 32'd2);
    check("t1_rsp_data", {24'd0, rsp_data}, 32'h5A);
    next_cycle();

    // req1 READ, counter data 0x3C only from T+2.
    cnt_out_data = 8'hEE;
    req1_valid = 1'b1; req1_op = 1'b1; req1_data = 8'h00;
    @(negedge clk);
    check("t2_ready1", {31'd0, req1_ready}, 32'd1);
    exp_q.push_back({1'b1, 8'h3C});
    next_cycle();
    req1_valid = 1'b0;
    @(negedge clk);
    check("t2_out_e_t1", {31'd0, cnt_out_e}, 32'd1);
    check("t2_busy_t1", {31'd0, busy}, 32'd1);
    next_cycle();
    cnt_out_data = 8'h3C;
    @(negedge clk);
    check("t2_out_e_t2", {31'd0, cnt_out_e}, 32'd0);
    check("t2_busy_t2", {31'd0, busy}, 32'd1);
    next_cycle();
    cnt_out_data = 8'h77;
    @(negedge clk);
    check("t2_rsp1", {30'd0, rsp0_valid, rsp1_valid}, 32'd1);
    check("t2_rsp_data", {24'd0, rsp_data}, 32'h3C);
    check("t2_busy_t3", {31'd0, busy}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("t2_busy_t4", {31'd0, busy}, 32'd0);
    next_cycle();

    // Random single commands.
    for (int i = 0; i < 8; i++) begin
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    // Contention: both hold LOADs from reset.
    apply_reset();
    req0_valid = 1'b1; req0_op = 1'b0; req0_data = 8'h11;
    req1_valid = 1'b1; req1_op = 1'b0; req1_data = 8'h22;
    for (int k = 0; k < 4; k++) begin
`ifdef CNT_ARB_FIXED_PRIO_EN
      g = 1'b0;
`else
      g = 1'(k % 2);
`endif
      @(negedge clk);
      check("cont_ready0", {31'd0, req0_ready}, {31'd0, !g});
      check("cont_ready1", {31'd0, req1_ready}, {31'd0, g});
      exp_q.push_back({g, g ? 8'h22 : 8'h11});
      load_q.push_back(g ? 8'h22 : 8'h11);
      next_cycle();
      @(negedge clk);
      check("cont_noready", {30'd0, req0_ready, req1_ready}, 32'd0);
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      repeat (2) next_cycle();
    end

    // Reset during WAIT of a READ: dropped, then LOAD accepted right after.
    cnt_out_data = 8'hA5;
    req0_valid = 1'b1; req0_op = 1'b1;
    next_cycle();
    req0_valid = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("mid_wait_state", {30'd0, dbg_state}, 32'd2);
    check("mid_ready0", {31'd0, req0_ready}, 32'd0);
    next_cycle();
    rst = 1'b0;
    req0_valid = 1'b1; req0_op = 1'b0; req0_data = 8'h99;
    @(negedge clk);
    check("mid_idle", {30'd0, dbg_state}, 32'd0);
    check("mid_outs", {27'd0, busy, rsp0_valid, rsp1_valid, cnt_load_e, cnt_out_e}, 32'd0);
    check("mid_data_zero", {16'd0, rsp_data, cnt_load_val}, 32'd0);
    check("mid_ready0_new", {31'd0, req0_ready}, 32'd1);
    exp_q.push_back({1'b0, 8'h99});
    load_q.push_back(8'h99);
    next_cycle();
    req0_valid = 1'b0;
    repeat (3) next_cycle();

    // RSP_LAT=3 instance READ.
    d3_req0_valid = 1'b1; d3_req0_op = 1'b1;
    @(negedge clk);
    check("l3_ready0", {31'd0, d3_req0_ready}, 32'd1);
    next_cycle();
    d3_req0_valid = 1'b0;
    @(negedge clk);
    check("l3_out_e_t1", {31'd0, d3_cnt_out_e}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("l3_out_e_t2", {31'd0, d3_cnt_out_e}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("l3_out_e_t3", {31'd0, d3_cnt_out_e}, 32'd0);
    next_cycle();
    d3_cnt_out_data = 8'hC3;
    @(negedge clk);
    check("l3_no_rsp_t4", {30'd0, d3_rsp0_valid, d3_busy}, 32'd1);
    next_cycle();
    d3_cnt_out_data = 8'h1F;
    @(negedge clk);
    check("l3_rsp0", {30'd0, d3_rsp0_valid, d3_rsp1_valid}, 32'd2);
    check("l3_rsp_data", {24'd0, d3_rsp_data}, 32'hC3);
    next_cycle();
    @(negedge clk);
    check("l3_busy_end", {31'd0, d3_busy}, 32'd0);

    repeat (3) next_cycle();
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("load_q_empty", load_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
